load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_pkg.sv | 33 +++
 rtl/load_store_unit_lane_align.sv | 72 +++++++
 rtl/load_store_unit.sv | 150 +++++++++++++++
 tb/tb_load_store_unit.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// ---------------------------------------------------------------------------
// load_store_unit_pkg
//   Shared definitions for the load/store unit:
//     SZ_BYTE / SZ_HALF / SZ_WORD : encodings of the 2-bit access size field
//     lsu_state_t                 : FSM state enumeration (IDLE/READ/WRITE/RESP)
//     size_align_fault()          : illegal-size / misalignment check
// ---------------------------------------------------------------------------
package load_store_unit_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_t;

    // True when the size code is illegal or the low address bits do not
    // respect the natural alignment of the access.
    function automatic logic size_align_fault(input logic [1:0] size,
                                              input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return addr_lo[0];
            SZ_WORD: return (addr_lo != 2'b00);
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// ---------------------------------------------------------------------------
// lsu_lane_align
//   Purely combinational lane handling for the load/store unit.
//   Ports:
//     size        in  2   access size (SZ_BYTE/SZ_HALF/SZ_WORD)
//     addr_lo     in  2   byte address bits [1:0] selecting the lane
//     is_unsigned in  1   zero-extend loads when 1, sign-extend when 0
//     mem_word    in  32  full memory word read for this access
//     store_data  in  32  right-aligned store data
//     load_data   out 32  extracted and extended load result
//     store_word  out 32  mem_word with the addressed lane replaced
//                         (store_data itself for word stores)
// ---------------------------------------------------------------------------
module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        is_unsigned,
    input  logic [31:0] mem_word,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = mem_word[7:0];
        case (addr_lo)
            2'd0:    byte_lane = mem_word[7:0];
            2'd1:    byte_lane = mem_word[15:8];
            2'd2:    byte_lane = mem_word[23:16];
            default: byte_lane = mem_word[31:24];
        endcase
        half_lane = addr_lo[1] ? mem_word[31:16] : mem_word[15:0];
    end

    always_comb begin
        load_data = '0;
        case (size)
            SZ_BYTE: load_data = {{24{byte_lane[7] & ~is_unsigned}}, byte_lane};
            SZ_HALF: load_data = {{16{half_lane[15] & ~is_unsigned}}, half_lane};
            SZ_WORD: load_data = mem_word;
            default: load_data = '0;
        endcase
    end

    always_comb begin
        store_word = mem_word;
        case (size)
            SZ_BYTE: begin
                case (addr_lo)
                    2'd0:    store_word[7:0]   = store_data[7:0];
                    2'd1:    store_word[15:8]  = store_data[7:0];
                    2'd2:    store_word[23:16] = store_data[7:0];
                    default: store_word[31:24] = store_data[7:0];
                endcase
            end
            SZ_HALF: begin
                if (addr_lo[1])
                    store_word[31:16] = store_data[15:0];
                else
                    store_word[15:0]  = store_data[15:0];
            end
            SZ_WORD: store_word = store_data;
            default: store_word = mem_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//   Single-outstanding load/store unit between a core request port and a
//   word-wide data memory with combinational read. Sub-word stores are done
//   as read-modify-write.
//   Ports:
//     clk, rst                  clock, asynchronous active-high reset
//     req_valid/req_ready       request handshake (ready only in IDLE)
//     req_we, req_size,         store flag, size code, load zero-extend,
//     req_unsigned, req_addr,   byte address, right-aligned store data
//     req_wdata
//     resp_valid                one-cycle completion pulse
//     resp_rdata, resp_err      load result (0 for stores/errors), error flag
//     mem_we, mem_addr, mem_wd  memory write enable, word address, write data
//     mem_rd                    memory read data for mem_addr
// ---------------------------------------------------------------------------
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    // One extra bit so that 4*MEM_WORDS = 2^32 would still compare correctly.
    localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) << 2;

    lsu_state_t  state_q, state_d;

    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic [31:0] rdata_q;

    logic        accept;
    logic        req_err;
    logic [31:0] word_addr;
    logic [31:0] load_data;
    logic [31:0] store_word;

    assign accept    = req_valid && (state_q == IDLE);
    assign req_err   = size_align_fault(req_size, req_addr[1:0]) ||
                       ({1'b0, req_addr} >= ADDR_LIMIT);
    assign word_addr = {addr_q[31:2], 2'b00};

    lsu_lane_align u_lane_align (
        .size        (size_q),
        .addr_lo     (addr_q[1:0]),
        .is_unsigned (uns_q),
        .mem_word    (rdata_q),
        .store_data  (wdata_q),
        .load_data   (load_data),
        .store_word  (store_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Request fields are frozen at the handshake; the memory word is captured
    // at the edge that closes READ and feeds both load extraction and the
    // read-modify-write merge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                we_q    <= req_we;
                size_q  <= req_size;
                uns_q   <= req_unsigned;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                err_q   <= req_err;
            end
            if (state_q == READ)
                rdata_q <= mem_rd;
        end
    end

    // Outputs decode from the state register only, so mem_we falls the
    // moment reset forces the state back to IDLE.
    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wd     = '0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_err)
                        state_d = RESP;
                    else if (req_we && (req_size == SZ_WORD))
                        state_d = WRITE;
                    else
                        state_d = READ;
                end
            end
            READ: begin
                mem_addr = word_addr;
                state_d  = we_q ? WRITE : RESP;
            end
            WRITE: begin
                mem_we   = 1'b1;
                mem_addr = word_addr;
                mem_wd   = store_word;
                state_d  = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = (we_q || err_q) ? 32'd0 : load_data;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    localparam int MEM_WORDS = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    // attached memory (environment) and the reference model's own copy
    logic [31:0] mem     [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];
    logic        bd_we = 1'b0;
    logic [7:0]  bd_idx = '0;
    logic [31:0] bd_val = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wd       (mem_wd),
        .mem_rd       (mem_rd)
    );

    assign mem_rd = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (bd_we)
            mem[bd_idx] <= bd_val;
        else if (mem_we)
            mem[mem_addr[9:2]] <= mem_wd;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Backdoor write to both the attached memory and the model (DUT idle).
    task automatic poke(input int idx, input logic [31:0] val);
        @(negedge clk);
        bd_we  = 1'b1;
        bd_idx = 8'(idx);
        bd_val = val;
        ref_mem[idx] = val;
        @(posedge clk);
        #1 bd_we = 1'b0;
    endtask

    // ---------------- reference model ----------------
    function automatic bit model_err(input logic [1:0] size, input logic [31:0] addr);
        longint a = longint'(addr);
        return (size == 2'd3) || (size == 2'd1 && a % 2 != 0) ||
               (size == 2'd2 && a % 4 != 0) || (a >= 4 * MEM_WORDS);
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                               input logic [31:0] addr);
        longint w  = longint'(ref_mem[addr / 4]);
        longint sh = 8 * (longint'(addr) % 4);
        longint v;
        if (size == 2'd0) begin
            v = (w >> sh) % 256;
            if (!uns && v >= 128) v = v - 256;
        end else if (size == 2'd1) begin
            v = (w >> sh) % 65536;
            if (!uns && v >= 32768) v = v - 65536;
        end else begin
            v = w;
        end
        return v[31:0];
    endfunction

    function automatic logic [31:0] model_store(input logic [1:0] size, input logic [31:0] addr,
                                                input logic [31:0] wdata);
        longint w  = longint'(ref_mem[addr / 4]);
        longint sh = 8 * (longint'(addr) % 4);
        longint mask;
        longint v;
        if (size == 2'd2) return wdata;
        mask = (size == 2'd0) ? 255 : 65535;
        v = (w & ~(mask << sh)) | ((longint'(wdata) & mask) << sh);
        return v[31:0];
    endfunction

    // One complete transaction: handshake, observe until response, compare.
    task automatic run_tx(input string tag, input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rd_out, output logic [31:0] wd_out);
        bit          exp_err;
        int          exp_lat;
        logic [31:0] exp_rd;
        logic [31:0] exp_wd;
        int          lat = 0;
        int          we_cnt = 0;
        bit          got = 0;
        logic [31:0] wd_seen = '0;
        logic [31:0] wa_seen = '0;
        logic [31:0] rd = '0;
        logic        err = 1'b0;
        logic [31:0] resp_ma = '0;
        logic        resp_mwe = 1'b0;

        exp_err = model_err(size, addr);
        exp_lat = exp_err ? 1 : (!we ? 2 : (size == 2'd2 ? 2 : 3));
        exp_rd  = (exp_err || we) ? 32'd0 : model_load(size, uns, addr);
        exp_wd  = (exp_err || !we) ? 32'd0 : model_store(size, addr, wdata);

        @(negedge clk);
        for (int i = 0; i < 10 && !req_ready; i++) @(negedge clk);
        check({tag, "/ready_idle"}, 32'(req_ready), 32'd1);

        req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        @(posedge clk);
        // keep requesting garbage while busy: it must be ignored
        #1;
        req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
        req_addr = $urandom; req_wdata = $urandom;

        for (int k = 1; k <= 8 && !got; k++) begin
            @(negedge clk);
            if (mem_we) begin
                we_cnt++;
                wd_seen = mem_wd;
                wa_seen = mem_addr;
            end
            if (resp_valid) begin
                got = 1; lat = k; rd = resp_rdata; err = resp_err;
                resp_ma = mem_addr; resp_mwe = mem_we;
                req_valid = 1'b0;
            end else begin
                check({tag, "/ready_busy"}, 32'(req_ready), 32'd0);
            end
        end
        req_valid = 1'b0;

        check({tag, "/resp_seen"}, 32'(got), 32'd1);
        check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "/err"}, 32'(err), 32'(exp_err));
        check({tag, "/rdata"}, rd, exp_rd);
        check({tag, "/we_pulses"}, 32'(we_cnt), (we && !exp_err) ? 32'd1 : 32'd0);
        if (we && !exp_err) begin
            check({tag, "/wd"}, wd_seen, exp_wd);
            check({tag, "/waddr"}, wa_seen, addr & 32'hFFFF_FFFC);
        end
        check({tag, "/resp_maddr"}, resp_ma, 32'd0);
        check({tag, "/resp_mwe"}, 32'(resp_mwe), 32'd0);

        @(negedge clk);
        check({tag, "/resp_single"}, 32'(resp_valid), 32'd0);
        check({tag, "/ready_after"}, 32'(req_ready), 32'd1);

        if (we && !exp_err) ref_mem[addr / 4] = exp_wd;
        rd_out = rd;
        wd_out = wd_seen;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "/ready"}, 32'(req_ready), 32'd1);
        check({tag, "/resp_valid"}, 32'(resp_valid), 32'd0);
        check({tag, "/resp_err"}, 32'(resp_err), 32'd0);
        check({tag, "/resp_rdata"}, resp_rdata, 32'd0);
        check({tag, "/mem_we"}, 32'(mem_we), 32'd0);
        check({tag, "/mem_addr"}, mem_addr, 32'd0);
        check({tag, "/mem_wd"}, mem_wd, 32'd0);
    endtask

    initial begin
        logic [31:0] rd, wd;
        int          seen_we, seen_resp;
        logic [1:0]  sz;
        logic [31:0] a;

        // reset state
        #2;
        check_reset_outputs("reset");
        for (int i = 0; i < MEM_WORDS; i++) poke(i, $urandom);
        @(negedge clk);
        check_reset_outputs("reset_hold");
        rst = 1'b0;

        // byte/halfword loads
        poke(2, 32'h1122_3344);
        run_tx("lb_9", 1'b0, 2'd0, 1'b0, 32'h9, 32'd0, rd, wd);
        check("lb_9_const", rd, 32'h0000_0033);
        run_tx("lb_b", 1'b0, 2'd0, 1'b0, 32'hB, 32'd0, rd, wd);
        check("lb_b_const", rd, 32'h0000_0011);
        poke(2, 32'h8000_5A5A);
        run_tx("lh_a", 1'b0, 2'd1, 1'b0, 32'hA, 32'd0, rd, wd);
        check("lh_a_const", rd, 32'hFFFF_8000);
        run_tx("lhu_a", 1'b0, 2'd1, 1'b1, 32'hA, 32'd0, rd, wd);
        check("lhu_a_const", rd, 32'h0000_8000);

        // sub-word store read-modify-write
        poke(1, 32'h0000_0006);
        run_tx("sb_5", 1'b1, 2'd0, 1'b0, 32'h5, 32'h0000_00AB, rd, wd);
        check("sb_5_const", wd, 32'h0000_AB06);

        // word store then load
        run_tx("sw_0", 1'b1, 2'd2, 1'b0, 32'h0, 32'hDEAD_BEEF, rd, wd);
        run_tx("lw_0", 1'b0, 2'd2, 1'b0, 32'h0, 32'd0, rd, wd);
        check("lw_0_const", rd, 32'hDEAD_BEEF);

        // error cases
        run_tx("err_lh3", 1'b0, 2'd1, 1'b0, 32'h3, 32'd0, rd, wd);
        run_tx("err_lw2", 1'b0, 2'd2, 1'b0, 32'h2, 32'd0, rd, wd);
        run_tx("err_lw400", 1'b0, 2'd2, 1'b0, 32'h400, 32'd0, rd, wd);
        run_tx("err_sz3", 1'b1, 2'd3, 1'b0, 32'h4, 32'h1234, rd, wd);
        run_tx("err_sb400", 1'b1, 2'd0, 1'b0, 32'h400, 32'h55, rd, wd);
        run_tx("edge_lb3ff", 1'b0, 2'd0, 1'b0, 32'h3FF, 32'd0, rd, wd);

        // reset during the READ cycle of a halfword store
        @(negedge clk);
        req_we = 1'b1; req_size = 2'd1; req_unsigned = 1'b0;
        req_addr = 32'h6; req_wdata = 32'hBEEF; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        #1 rst = 1'b1;
        #1 check_reset_outputs("rst_read");
        @(negedge clk);
        rst = 1'b0;
        seen_we = 0; seen_resp = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (mem_we) seen_we++;
            if (resp_valid) seen_resp++;
        end
        check("rst_read/no_we", 32'(seen_we), 32'd0);
        check("rst_read/no_resp", 32'(seen_resp), 32'd0);
        check("rst_read/ready", 32'(req_ready), 32'd1);
        run_tx("lw_after_rst", 1'b0, 2'd2, 1'b0, 32'h4, 32'd0, rd, wd);

        // reset during WRITE: enable drops at once, memory left untouched
        @(negedge clk);
        req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h10; req_wdata = 32'hCAFE_F00D; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("rst_write/we_before", 32'(mem_we), 32'd1);
        check("rst_write/addr_before", mem_addr, 32'h10);
        #1 rst = 1'b1;
        #1 check("rst_write/we_async", 32'(mem_we), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_tx("lw_after_wrst", 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, rd, wd);

        // randomized traffic against the model
        for (int i = 0; i < 200; i++) begin
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0)
                a = 32'($urandom_range(32'h3F0, 32'h40F));
            else
                a = 32'($urandom_range(0, 63));
            run_tx($sformatf("rnd%0d", i), 1'($urandom), sz, 1'($urandom), a, $urandom, rd, wd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
